// File: rtl/cam_sync_pkg.sv
// Shared types and geometry constants for the camera sync front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_sync_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        LOCKED
    } lock_state_t;

    localparam int PERIOD_W = 12;
    localparam int COUNT_W  = 9;

    // Camera line is two CLK cycles per VGA pixel of the 784x510 raster.
    localparam int VGA_H_TOTAL  = 784;
    localparam int VGA_V_TOTAL  = 510;
    localparam int LINE_NOM_DEF = VGA_H_TOTAL * 2;
    localparam int LINE_TOL_DEF = 8;

    function automatic logic period_in_window(
        input logic [PERIOD_W-1:0] period,
        input logic [PERIOD_W-1:0] lo,
        input logic [PERIOD_W-1:0] hi
    );
        return (period != '1) && (period >= lo) && (period <= hi);
    endfunction

endpackage

// File: rtl/cam_sync_lock_sync_filter.sv
// Synchroniser + glitch filter + falling-edge detect for one raw sync input.
// Latency: fall pulse 2+FILT_LEN-1 cycles after the raw sample edge.
// Backpressure: none; fall is a fire-and-forget one-cycle pulse.
module sync_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILT_LEN) + 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] run_cnt;

    // run_cnt counts consecutive synchronised samples disagreeing with level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILT_LEN - 1)) begin
                level   <= sync2;
                run_cnt <= '0;
                fall    <= ~sync2;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cam_sync_lock.sv
// Camera HSYNC/VSYNC lock monitor; forwards edge pulses only while line period is stable.
// Latency: output pulses 2+FILT_LEN cycles after the raw sample edge.
// Backpressure: none; downstream VGA controller free-runs when pulses are withheld.
module cam_sync_lock
    import cam_sync_pkg::*;
#(
    parameter int FILT_LEN   = 3,
    parameter int LINE_NOM   = LINE_NOM_DEF,
    parameter int LINE_TOL   = LINE_TOL_DEF,
    parameter int LOCK_LINES = 4,
    parameter int MISS_MAX   = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CAM_HSYNC,
    input  logic                CAM_VSYNC,
    output logic                CamHsync_EDGE,
    output logic                CamVsync_EDGE,
    output logic [PERIOD_W-1:0] CamLinePeriod,
    output logic [COUNT_W-1:0]  CamLineCount,
    output logic                Locked,
    output logic                SyncErr
);

    localparam int GW = $clog2(LOCK_LINES + 1);
    localparam int MW = $clog2(MISS_MAX + 1);
    localparam logic [PERIOD_W-1:0] P_LO = PERIOD_W'(LINE_NOM - LINE_TOL);
    localparam logic [PERIOD_W-1:0] P_HI = PERIOD_W'(LINE_NOM + LINE_TOL);

    logic                h_level;
    logic                v_level;
    logic                hf;
    logic                vf;
    logic [PERIOD_W-1:0] period_cnt;
    logic                period_good;
    lock_state_t         state;
    logic [GW-1:0]       good_cnt;
    logic [MW-1:0]       miss_cnt;
    logic                unused_levels;

    sync_filter #(.FILT_LEN(FILT_LEN)) u_hsync_filter (
        .clk   (CLK),
        .rst_n (RST_N),
        .din   (CAM_HSYNC),
        .level (h_level),
        .fall  (hf)
    );

    sync_filter #(.FILT_LEN(FILT_LEN)) u_vsync_filter (
        .clk   (CLK),
        .rst_n (RST_N),
        .din   (CAM_VSYNC),
        .level (v_level),
        .fall  (vf)
    );

    assign unused_levels = h_level ^ v_level;
    assign period_good   = period_in_window(period_cnt, P_LO, P_HI);

    // Loading 1 on hf makes the pre-load value the exact hf-to-hf distance.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            period_cnt    <= '0;
            CamLinePeriod <= '0;
            CamLineCount  <= '0;
        end else begin
            if (hf) begin
                period_cnt    <= PERIOD_W'(1);
                CamLinePeriod <= period_cnt;
            end else if (period_cnt != '1) begin
                period_cnt <= period_cnt + PERIOD_W'(1);
            end
            if (vf) begin
                CamLineCount <= '0;
            end else if (hf && CamLineCount != '1) begin
                CamLineCount <= CamLineCount + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            good_cnt      <= '0;
            miss_cnt      <= '0;
            Locked        <= 1'b0;
            CamHsync_EDGE <= 1'b0;
            CamVsync_EDGE <= 1'b0;
            SyncErr       <= 1'b0;
        end else begin
            CamHsync_EDGE <= 1'b0;
            SyncErr       <= 1'b0;
            CamVsync_EDGE <= vf && Locked;
            if (hf) begin
                unique case (state)
                    IDLE: begin
                        state    <= HUNT;
                        good_cnt <= '0;
                    end
                    HUNT: begin
                        if (!period_good) begin
                            good_cnt <= '0;
                        end else if (good_cnt == GW'(LOCK_LINES - 1)) begin
                            state    <= LOCKED;
                            Locked   <= 1'b1;
                            good_cnt <= '0;
                            miss_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end
                    LOCKED: begin
                        if (period_good) begin
                            CamHsync_EDGE <= 1'b1;
                            miss_cnt      <= '0;
                        end else begin
                            SyncErr <= 1'b1;
                            if (miss_cnt == MW'(MISS_MAX - 1)) begin
                                state    <= HUNT;
                                Locked   <= 1'b0;
                                good_cnt <= '0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MW'(1);
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        Locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/cam_sync_lock.md
# cam_sync_lock

Front end of the camera-to-VGA path. Samples the raw camera HSYNC/VSYNC, synchronises and deglitches them, and checks the line period against nominal. It emits one-cycle CamHsync_EDGE / CamVsync_EDGE pulses to the VGA timing controller only while locked. The VGA controller free-runs whenever this block withholds pulses.

## Interface
- FILT_LEN, 3: consecutive equal synchronised samples required to accept a level change.
- LINE_NOM, 1568: nominal camera line period in CLK cycles (784 VGA pixels × 2).
- LINE_TOL, 8: accepted period is LINE_NOM ± LINE_TOL, inclusive.
- LOCK_LINES, 4: consecutive good periods needed to lock.
- MISS_MAX, 2: consecutive bad periods that drop lock.
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- CAM_HSYNC  in  1  raw camera horizontal sync; asynchronous, active-low, idle high.
- CAM_VSYNC  in  1  raw camera vertical sync; asynchronous, active-low, idle high.
- CamHsync_EDGE  out  1  one-cycle pulse for a validated HSYNC falling edge (locked only).
- CamVsync_EDGE  out  1  one-cycle pulse for a VSYNC falling edge (locked only).
- CamLinePeriod  out  12  last measured HSYNC-to-HSYNC distance in clocks.
- CamLineCount  out  9  HSYNC edges since the last VSYNC edge; saturates at 511.
- Locked  out  1  high in the LOCKED state.
- SyncErr  out  1  one-cycle pulse when an out-of-tolerance period is seen while LOCKED.

## Operation
- Per input:
  - 2-flop synchroniser, both flops reset to 1.
  - Glitch filter: the filtered level changes only after FILT_LEN consecutive synchronised samples of the new level. The filtered level resets to 1.
  - Falling-edge detect on the filtered level produces an internal pulse (hf for HSYNC, vf for VSYNC).
- Period counter, 12 bit:
  - Increments every cycle and saturates at 4095.
  - On hf it is loaded with 1, and its pre-load value is latched into CamLinePeriod. This makes CamLinePeriod the exact cycle distance between consecutive hf.
  - A period is good if it is in [LINE_NOM−LINE_TOL, LINE_NOM+LINE_TOL]. A saturated count is always bad.
- State machine, initial state IDLE:
  - IDLE: the first hf moves to HUNT; GoodCnt=0. No period is evaluated.
  - HUNT: a good hf increments GoodCnt; a bad hf sets GoodCnt=0. When GoodCnt reaches LOCK_LINES, go to LOCKED with MissCnt=0.
  - LOCKED, good hf: forward the pulse and set MissCnt=0.
  - LOCKED, bad hf: suppress the pulse, pulse SyncErr and increment MissCnt. When MissCnt reaches MISS_MAX, go to HUNT with GoodCnt=0.
- CamVsync_EDGE equals vf registered, gated by Locked.
- CamLineCount:
  - Cleared on vf, incremented on hf.
  - When vf and hf occur in the same cycle, vf wins and the count becomes 0.
- Reset, including mid-frame: all counters 0, state IDLE, CamLinePeriod 0. All outputs are low or 0 after reset. No edge pulse may result from the reset release itself.

## Timing
- Edge latency: the raw input is sampled low at edge k. The output pulse is high for exactly one cycle, following edge k+2+FILT_LEN (that is, edge k+5 at default).
- hf and vf share the same latency. Simultaneous raw edges give same-cycle outputs.
- Glitches shorter than FILT_LEN cycles on the synchronised signal produce no pulse and leave the filtered level unchanged.
- Locked, the state change and CamLinePeriod all update in the same cycle as the associated output pulse would appear.
- Lock timing: Locked rises with hf #(LOCK_LINES+1) after IDLE, which is the 5th edge at default. The first forwarded CamHsync_EDGE is hf #(LOCK_LINES+2).
- The edge that causes the LOCKED→HUNT transition is not forwarded.

## Structure
- Package cam_sync_pkg holds:
  - the state enum {IDLE, HUNT, LOCKED};
  - the period/count widths (12, 9);
  - the default LINE_NOM/LINE_TOL constants, shared with the VGA controller's 784×510 geometry.
- Sub-module sync_filter: synchroniser, glitch filter and falling-edge detector. Parameter FILT_LEN; outputs the filtered level and the fall pulse. Instantiated twice.

## Test plan
- Clean HSYNC at period 1568 (low for 188 cycles) after reset:
  - Locked rises at hf #5.
  - First CamHsync_EDGE at hf #6.
  - CamLinePeriod = 1568.
- Periods 1560 and 1576 are accepted. 1559 and 1577 in HUNT reset GoodCnt, so lock is delayed by a further 4 good lines.
- Locked, one line at 1500: SyncErr pulses, that edge is suppressed and Locked stays high. Two consecutive bad lines: Locked drops on the second, with no pulse on either.
- 2-cycle low glitch on HSYNC mid-line: no pulse, CamLinePeriod is unchanged and the lock is kept.
- VSYNC and HSYNC falling at the same raw edge while locked:
  - both pulses occur in the same cycle, 5 cycles after sampling;
  - CamLineCount = 0;
  - the next HSYNC gives 1.
- RST_N asserted mid-line while locked:
  - all outputs are 0 immediately;
  - after release with CAM_HSYNC held high, no pulse occurs;
  - relock requires 5 edges.
